// File: rtl/instr_fetch.sv
// Byte-serial instruction fetch: assembles 3-byte big-endian words from a
// byte ROM, holds them for the decoder, and supports jumps and halting.
module instr_fetch #(
  parameter logic [5:0] START_ADDR = 6'd0,
  parameter logic [5:0] END_ADDR   = 6'd33
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic        rom_cs,
  output logic [5:0]  rom_addr,
  input  logic [7:0]  rom_data,
  output logic [23:0] instr,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        jmp_en,
  input  logic [5:0]  jmp_addr,
  output logic [5:0]  pc,
  output logic        halted
);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    HOLD,
    HALT
  } state_e;

  state_e      state_q, state_d;
  logic [5:0]  pc_q, pc_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [15:0] part_q, part_d;
  logic [23:0] instr_q, instr_d;
  logic        valid_q, valid_d;
  logic        cs_q, cs_d;
  logic [5:0]  addr_q, addr_d;
  logic        halt_q, halt_d;
  logic [5:0]  pc_inc;

  assign pc_inc = pc_q + 6'd3;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    part_d  = part_q;
    instr_d = instr_q;
    valid_d = valid_q;
    unique case (state_q)
      IDLE, HALT: begin
        if (start) begin
          pc_d    = START_ADDR;
          cnt_d   = 2'd0;
          state_d = (START_ADDR >= END_ADDR) ? HALT : FETCH;
        end
      end
      FETCH: begin
        if (jmp_en) begin
          pc_d    = jmp_addr;
          cnt_d   = 2'd0;
          valid_d = 1'b0;
          state_d = (jmp_addr >= END_ADDR) ? HALT : FETCH;
        end else begin
          unique case (cnt_q)
            2'd0: begin
              part_d[15:8] = rom_data;
              cnt_d        = 2'd1;
            end
            2'd1: begin
              part_d[7:0] = rom_data;
              cnt_d       = 2'd2;
            end
            default: begin
              // instr only changes once a whole word is in hand
              instr_d = {part_q, rom_data};
              valid_d = 1'b1;
              cnt_d   = 2'd0;
              state_d = HOLD;
            end
          endcase
        end
      end
      HOLD: begin
        if (jmp_en) begin
          pc_d    = jmp_addr;
          cnt_d   = 2'd0;
          valid_d = 1'b0;
          state_d = (jmp_addr >= END_ADDR) ? HALT : FETCH;
        end else if (instr_ready) begin
          pc_d    = pc_inc;
          valid_d = 1'b0;
          state_d = (pc_inc >= END_ADDR) ? HALT : FETCH;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cs_d   = (state_d == FETCH);
    addr_d = cs_d ? (pc_d + {4'd0, cnt_d}) : pc_d;
    halt_d = (state_d == HALT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= START_ADDR;
      cnt_q   <= 2'd0;
      part_q  <= 16'h0000;
      instr_q <= 24'h000000;
      valid_q <= 1'b0;
      cs_q    <= 1'b0;
      addr_q  <= START_ADDR;
      halt_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      part_q  <= part_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      cs_q    <= cs_d;
      addr_q  <= addr_d;
      halt_q  <= halt_d;
    end
  end

  assign rom_cs      = cs_q;
  assign rom_addr    = addr_q;
  assign instr       = instr_q;
  assign instr_valid = valid_q;
  assign pc          = pc_q;
  assign halted      = halt_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed scenarios plus random
// traffic against a phase-level reference model with a ROM-word lookup.
module tb_instr_fetch;

  localparam int SA = 0;
  localparam int EA = 33;
  localparam int P_IDLE = -1;
  localparam int P_HALT = -2;
  localparam int P_HOLD = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        rom_cs;
  logic [5:0]  rom_addr;
  logic [7:0]  rom_data;
  logic [23:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic        jmp_en;
  logic [5:0]  jmp_addr;
  logic [5:0]  pc;
  logic        halted;

  logic [7:0] rom [64];
  int checks = 0;
  int fails  = 0;

  int          ph;
  int          mpc;
  logic [23:0] minstr;

  always #5 clk = ~clk;

  assign rom_data = rom[rom_addr];

  instr_fetch #(
    .START_ADDR(6'd0),
    .END_ADDR  (6'd33)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .rom_cs     (rom_cs),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .instr      (instr),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .jmp_en     (jmp_en),
    .jmp_addr   (jmp_addr),
    .pc         (pc),
    .halted     (halted)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [23:0] word(input int a);
    return {rom[a % 64], rom[(a + 1) % 64], rom[(a + 2) % 64]};
  endfunction

  task automatic model_reset();
    ph     = P_IDLE;
    mpc    = SA;
    minstr = 24'h0;
  endtask

  task automatic model_goto(input int a);
    mpc = a;
    ph  = (a >= EA) ? P_HALT : 0;
  endtask

  task automatic model_step(input bit s, input bit j, input int ja,
                            input bit r);
    if (ph == P_IDLE || ph == P_HALT) begin
      if (s) model_goto(SA);
    end else if (j) begin
      model_goto(ja);
    end else if (ph == P_HOLD) begin
      if (r) model_goto((mpc + 3) % 64);
    end else if (ph == 2) begin
      minstr = word(mpc);
      ph     = P_HOLD;
    end else begin
      ph = ph + 1;
    end
  endtask

  task automatic check_all();
    bit f;
    f = (ph >= 0 && ph <= 2);
    chk("rom_cs", rom_cs, f);
    chk("rom_addr", rom_addr, f ? (mpc + ph) % 64 : mpc);
    chk("instr", instr, minstr);
    chk("instr_valid", instr_valid, ph == P_HOLD);
    chk("pc", pc, mpc);
    chk("halted", halted, ph == P_HALT);
  endtask

  task automatic step(input bit s, input bit j, input int ja, input bit r);
    start       = s;
    jmp_en      = j;
    jmp_addr    = ja[5:0];
    instr_ready = r;
    @(posedge clk);
    model_step(s, j, ja, r);
    #1;
    check_all();
  endtask

  task automatic wait_valid();
    for (int i = 0; i < 10; i++) begin
      if (instr_valid) return;
      step(1'b0, 1'b0, 0, 1'b0);
    end
    chk("valid_timeout", instr_valid, 1);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_cs"}, rom_cs, 0);
    chk({tag, "_addr"}, rom_addr, SA);
    chk({tag, "_instr"}, instr, 0);
    chk({tag, "_valid"}, instr_valid, 0);
    chk({tag, "_pc"}, pc, SA);
    chk({tag, "_halted"}, halted, 0);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) rom[i] = 8'h00;
    rom[7]  = 8'h40;
    rom[13] = 8'h41;
    rom[14] = 8'h41;
    rom[23] = 8'hE0;
    rom[32] = 8'h55;
    start = 0; jmp_en = 0; jmp_addr = 0; instr_ready = 0;
    rst_n = 0;
    model_reset();
    #1;
    check_reset_vals("rst");
    #11 rst_n = 1;

    // sequential fetch from reset
    step(1'b1, 1'b0, 0, 1'b1);
    wait_valid();
    chk("first_instr", instr, 24'h000000);
    chk("first_pc", pc, 0);
    step(1'b0, 1'b0, 0, 1'b1);
    wait_valid();
    step(1'b0, 1'b0, 0, 1'b1);
    wait_valid();
    chk("third_instr", instr, 24'h004000);
    chk("third_pc", pc, 6);
    step(1'b0, 1'b0, 0, 1'b1);
    wait_valid();
    step(1'b0, 1'b0, 0, 1'b1);
    wait_valid();

    // stall at pc=12
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 0, 1'b0);
    chk("stall_instr", instr, 24'h004141);
    chk("stall_cs", rom_cs, 0);
    step(1'b0, 1'b0, 0, 1'b1);
    chk("after_stall_pc", pc, 15);

    // run to halt
    for (int i = 0; i < 100 && !halted; i++) begin
      if (instr_valid && pc == 6'd30) chk("last_instr", instr, 24'h000055);
      step(1'b0, 1'b0, 0, 1'b1);
    end
    chk("halt_flag", halted, 1);
    chk("halt_pc", pc, 33);
    chk("halt_cs", rom_cs, 0);
    step(1'b0, 1'b1, 3, 1'b1);
    chk("halt_ignores_jmp", pc, 33);
    step(1'b1, 1'b0, 0, 1'b1);
    chk("restart_pc", pc, 0);
    chk("restart_cs", rom_cs, 1);

    // jump during byte_cnt=1
    step(1'b0, 1'b0, 0, 1'b1);
    step(1'b0, 1'b1, 21, 1'b1);
    wait_valid();
    chk("jmp_instr", instr, 24'h0000E0);
    chk("jmp_pc", pc, 21);
    step(1'b0, 1'b1, 40, 1'b1);
    chk("jmp_halt", halted, 1);

    // jump and accept together
    step(1'b1, 1'b0, 0, 1'b0);
    wait_valid();
    step(1'b0, 1'b1, 9, 1'b1);
    chk("jmpacc_pc", pc, 9);
    step(1'b0, 1'b0, 0, 1'b1);
    step(1'b0, 1'b0, 0, 1'b1);
    chk("jmpacc_gap", instr_valid, 0);
    step(1'b0, 1'b0, 0, 1'b1);
    chk("jmpacc_valid", instr_valid, 1);
    chk("jmpacc_instr", instr, 24'h000000);

    // async reset mid-fetch
    step(1'b0, 1'b0, 0, 1'b1);
    step(1'b0, 1'b0, 0, 1'b1);
    @(negedge clk);
    rst_n = 0;
    #1;
    model_reset();
    check_reset_vals("async_rst");
    #2 rst_n = 1;
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 0, 1'b1);

    // random traffic
    for (int i = 0; i < 2000; i++) begin
      step($urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0,
           int'($urandom_range(0, 63)), $urandom_range(0, 9) < 6);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 The block SHALL have parameter START_ADDR, default 6'd0, meaning the program-counter value loaded at reset and on start.
REQ-002 The block SHALL have parameter END_ADDR, default 6'd33, meaning the first byte address at or beyond which fetching halts.
REQ-003 The block SHALL have port clk, input, 1 bit: single clock, all state changes on the rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 The block SHALL have port start, input, 1 bit: begins fetching from START_ADDR when in IDLE or HALT.
REQ-006 The block SHALL have port rom_cs, output, 1 bit: chip select to the byte-wide instruction ROM.
REQ-007 The block SHALL have port rom_addr, output, 6 bits: byte address to the ROM.
REQ-008 The block SHALL have port rom_data, input, 8 bits: ROM byte, valid within the same cycle the address is presented.
REQ-009 The block SHALL have port instr, output, 24 bits: assembled instruction word.
REQ-010 The block SHALL have port instr_valid, output, 1 bit: instr holds a complete instruction.
REQ-011 The block SHALL have port instr_ready, input, 1 bit: the decoder accepts instr.
REQ-012 The block SHALL have port jmp_en, input, 1 bit: redirect fetch.
REQ-013 The block SHALL have port jmp_addr, input, 6 bits: jump target byte address.
REQ-014 The block SHALL have port pc, output, 6 bits: byte address of the current instruction.
REQ-015 The block SHALL have port halted, output, 1 bit: high in HALT state.

Function
REQ-016 The block SHALL implement the states IDLE, FETCH, HOLD and HALT as a registered state machine.
REQ-017 Each instruction SHALL be exactly 3 ROM bytes, big-endian: byte pc maps to instr[23:16], pc+1 to instr[15:8], and pc+2 to instr[7:0].
REQ-018 In FETCH, the block SHALL drive rom_cs=1 and rom_addr=pc+byte_cnt, where byte_cnt is 0..2.
REQ-019 In FETCH, the block SHALL capture rom_data into the matching instr byte on each clock edge and then increment byte_cnt.
REQ-020 On the capture with byte_cnt=2, the block SHALL move to HOLD, set instr_valid=1 and clear byte_cnt; latency from entering FETCH to instr_valid is 3 clocks.
REQ-021 In IDLE, HOLD and HALT, the block SHALL drive rom_cs=0 and rom_addr=pc.
REQ-022 In HOLD, instr and instr_valid SHALL stay stable until instr_ready=1.
REQ-023 On an edge where instr_valid and instr_ready are both 1, the block SHALL set pc=pc+3 and instr_valid=0; the next state is HALT if the new pc>=END_ADDR, else FETCH.
REQ-024 All address arithmetic (pc+byte_cnt, pc+3) SHALL be 6-bit modulo 64, with wrap-around, and no error flagged.
REQ-025 jmp_en=1 in FETCH or HOLD SHALL have priority over every other event: pc=jmp_addr, byte_cnt=0, instr_valid=0, and a partial fetch is discarded.
REQ-026 After a jump, the next state SHALL be HALT if jmp_addr>=END_ADDR, else FETCH.
REQ-027 When jmp_en and instr_valid&&instr_ready occur in the same cycle, the held instruction SHALL count as consumed and pc SHALL take jmp_addr, not pc+3.
REQ-028 jmp_en SHALL be ignored in IDLE and HALT.
REQ-029 start=1 in IDLE or HALT SHALL set pc=START_ADDR, byte_cnt=0 and state=FETCH; if START_ADDR>=END_ADDR the state SHALL go to HALT instead.
REQ-030 start SHALL be ignored in FETCH and HOLD.
REQ-031 halted SHALL be 1 exactly when the state is HALT.
REQ-032 instr SHALL retain its last value after acceptance, a jump or a halt.

Reset
REQ-033 While rst_n=0, independent of clk, the block SHALL force: state=IDLE, pc=START_ADDR, byte_cnt=0, instr=24'h000000, instr_valid=0, rom_cs=0, rom_addr=START_ADDR, halted=0.
REQ-034 Reset asserted mid-fetch or in HOLD SHALL discard all partial and held data, and no ROM access SHALL occur until start.

Verification
Bench ROM image: byte 7=0x40, bytes 13/14=0x41, byte 23=0xE0, byte 32=0x55, all other bytes 0x00.
REQ-035 Reset, then start with instr_ready=1 -> instr_valid is high 3 clocks after entering FETCH with instr=0x000000 and pc=0; the third instruction (pc=6) gives instr=0x004000.
REQ-036 Hold instr_ready=0 for 5 clocks at pc=12 -> instr=0x004141 held stable with rom_cs=0; on ready, pc=15.
REQ-037 Run to completion with ready=1 -> the last instruction at pc=30 gives 0x000055, then pc=33, halted=1 and rom_cs=0; a second start restarts at pc=0.
REQ-038 jmp_en with jmp_addr=21 asserted during byte_cnt=1 of a fetch -> the partial fetch is discarded and the next instr=0x0000E0 with pc=21; jmp_addr=40 -> HALT.
REQ-039 Jump and accept in the same cycle -> pc=jmp_addr (not pc+3) and instr_valid drops for 3 clocks.
REQ-040 rst_n pulsed low between clock edges during FETCH -> outputs reach reset values immediately, and nothing resumes without start.
